// File: rtl/detector_pkg.sv
// Shared constants and types for the serial pattern detector.
package detector_pkg;

   localparam int              DEF_PAT_LEN = 4;
   localparam logic [3:0]      DEF_PATTERN = 4'b1011;
   localparam int              DEF_CNT_W   = 8;

   typedef logic [DEF_CNT_W-1:0] count_t;

endpackage : detector_pkg

// File: rtl/detector_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module detector_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] value
);

   logic [W-1:0] value_q;
   logic [W-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (inc && (value_q != '1)) begin
         value_d = value_q + W'(1);
      end
   end

   // NOTE: reset is sampled only on the clock edge; there is no async path.
   always_ff @(posedge clk) begin
      if (!rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule : detector_sat_counter

// File: rtl/detector.sv
// Serial bit-pattern detector with registered match pulse and saturating match count.
// Define DETECTOR_OVERLAP_EN to let a pattern suffix begin the next match.
module detector
   import detector_pkg::*;
#(
   parameter int                 PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   parameter int                 CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             data_in,
   output logic             detect,
   output logic [CNT_W-1:0] count
);

   localparam int VW = $clog2(PAT_LEN + 1);

   logic [PAT_LEN-1:0] hist_q;
   logic [PAT_LEN-1:0] hist_d;
   logic [VW-1:0]      vld_q;
   logic [VW-1:0]      vld_d;
   logic [VW-1:0]      vld_nxt;
   logic               detect_q;
   logic               match;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hist_d  = {hist_q[PAT_LEN-2:0], data_in};
      vld_nxt = (vld_q == VW'(PAT_LEN)) ? vld_q : vld_q + VW'(1);
      match   = (vld_nxt == VW'(PAT_LEN)) && (hist_d == PATTERN);
`ifdef DETECTOR_OVERLAP_EN
      vld_d   = vld_nxt;
`else
      // Dropping the valid count is enough; stale history bits can never match again.
      vld_d   = match ? '0 : vld_nxt;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q   <= '0;
         vld_q    <= '0;
         detect_q <= 1'b0;
      end else begin
         hist_q   <= hist_d;
         vld_q    <= vld_d;
         detect_q <= match;
      end
   end

   detector_sat_counter #(
      .W(CNT_W)
   ) u_sat_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (match),
      .value(count)
   );

   assign detect = detect_q;

endmodule : detector

// File: tb/tb_detector.sv
// Self-checking bench for detector: vector table, directed corner cases and a random run.
module tb_detector;
   import detector_pkg::*;

   typedef struct {
      logic   rst;
      logic   din;
      logic   det;
      count_t cnt;
   } vec_t;

   typedef struct {
      logic   det;
      count_t cnt;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b0;
   logic   data_in = 1'b0;
   logic   detect;
   count_t count;

   int     total = 0;
   int     bad = 0;
   int     pulses = 0;

   exp_t   sb[$];
   logic   mbits[$];
   count_t mcnt = '0;

   detector dut (
      .clk    (clk),
      .rst    (rst),
      .data_in(data_in),
      .detect (detect),
      .count  (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: remembers the bits seen since reset or since the last non-overlap clear.
   task automatic model_step(input logic r, input logic d, output exp_t e);
      logic [3:0] w;
      logic       m;
      w = '0;
      m = 1'b0;
      if (!r) begin
         mbits.delete();
         mcnt = '0;
      end else begin
         mbits.push_back(d === 1'b1);
         if (mbits.size() > DEF_PAT_LEN) void'(mbits.pop_front());
         if (mbits.size() == DEF_PAT_LEN) begin
            foreach (mbits[i]) w = {w[2:0], mbits[i]};
            m = (w == DEF_PATTERN);
         end
         if (m) begin
            if (mcnt != '1) mcnt = mcnt + 1'b1;
`ifndef DETECTOR_OVERLAP_EN
            mbits.delete();
`endif
         end
      end
      e.det = m;
      e.cnt = mcnt;
   endtask

   task automatic apply_and_check(input logic r, input logic d);
      exp_t e;
      rst = r;
      data_in = d;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("detect", detect, e.det);
      check("count", count, e.cnt);
      if (detect === 1'b1) pulses++;
   endtask

   task automatic step(input logic r, input logic d);
      exp_t e;
      model_step(r, d, e);
      sb.push_back(e);
      apply_and_check(r, d);
   endtask

   task automatic feed_1011(input int reps);
      for (int k = 0; k < reps; k++) begin
         step(1'b1, 1'b1);
         step(1'b1, 1'b0);
         step(1'b1, 1'b1);
         step(1'b1, 1'b1);
      end
   endtask

   vec_t vecs[13];

   initial begin
      exp_t e;
      int   p0;
      // Reset hold, single match, then a reset in the middle of a partial pattern.
      vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'd1};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'd1};
      vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd1};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd1};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 8'd0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 8'd0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 8'd0};

      @(negedge clk);
      for (int i = 0; i < 13; i++) begin
         model_step(vecs[i].rst, vecs[i].din, e);
         e.det = vecs[i].det;
         e.cnt = vecs[i].cnt;
         sb.push_back(e);
         apply_and_check(vecs[i].rst, vecs[i].din);
      end

      // Overlap corner: 1011011 gives two matches only when overlap is enabled.
      step(1'b0, 1'b0);
      p0 = pulses;
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
`ifdef DETECTOR_OVERLAP_EN
      check("overlap_pulses", pulses - p0, 2);
      check("overlap_count", count, 2);
`else
      check("overlap_pulses", pulses - p0, 1);
      check("overlap_count", count, 1);
`endif

      // Saturation: 300 back-to-back patterns; count pins at 255 and detect keeps pulsing.
      step(1'b0, 1'b0);
      feed_1011(290);
      check("sat_count_hold", count, 255);
      p0 = pulses;
      feed_1011(10);
      check("sat_pulses", pulses - p0, 10);
      check("sat_count_final", count, 255);

      // Random stream with occasional resets.
      step(1'b0, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 199) != 0), 1'($urandom));
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_detector
